// File: rtl/bam_pkg.sv
// Shared types and helpers for the broken-array sequential multiplier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturate a run-time break level to its meaningful maximum.
    function automatic logic [31:0] bam_clamp(input logic [31:0] x, input logic [31:0] lim);
        return (x > lim) ? lim : x;
    endfunction

endpackage

// File: rtl/bam_seq_mult_if.sv
// Operand and result handshake bundle for bam_seq_mult.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the flow control.
interface bam_seq_mult_if #(
    parameter int WIDTH = 8,
    parameter int HBITS = $clog2(WIDTH + 1),
    parameter int VBITS = $clog2(2 * WIDTH + 1)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [HBITS-1:0]   in_h;
    logic [VBITS-1:0]   in_v;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;

    modport master (
        output in_valid, in_a, in_b, in_h, in_v, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, in_h, in_v, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

// File: rtl/bam_pp_row.sv
// One masked partial-product row: a gated by b_bit, columns i+row<v cleared.
// Latency: combinational.
// Backpressure: none.
module bam_pp_row #(
    parameter int WIDTH = 8,
    parameter int HBITS = $clog2(WIDTH + 1),
    parameter int VBITS = $clog2(2 * WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             b_bit_i,
    input  logic [HBITS-1:0] row_i,
    input  logic [VBITS-1:0] v_i,
    output logic [WIDTH-1:0] pp_o
);
    always_comb begin
        pp_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp_o[i] = a_i[i] & b_bit_i & ((i + int'(row_i)) >= int'(v_i));
        end
    end
endmodule

// File: rtl/bam_seq_mult.sv
// Broken-array unsigned multiplier, one partial-product row per cycle, h/v per transaction.
// Latency: accept in cycle t -> out_valid in cycle t+1+max(WIDTH-h,0).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module bam_seq_mult
    import bam_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HBITS = $clog2(WIDTH + 1),
    parameter int VBITS = $clog2(2 * WIDTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    bam_seq_mult_if.slave  bus
);
    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [VBITS-1:0]   v_q;
    logic [HBITS-1:0]   row_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] out_prod_q;

    logic [HBITS-1:0]   h_acc;
    logic [VBITS-1:0]   v_acc;
    logic               b_bit;
    logic [WIDTH-1:0]   pp_row;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = out_prod_q;

    always_comb begin
        h_acc = HBITS'(bam_clamp(32'(bus.in_h), 32'(WIDTH)));
        v_acc = VBITS'(bam_clamp(32'(bus.in_v), 32'(2 * WIDTH)));
    end

    always_comb begin
        b_bit = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (int'(row_q) == j) b_bit = b_q[j];
        end
    end

    bam_pp_row #(.WIDTH(WIDTH), .HBITS(HBITS), .VBITS(VBITS)) u_pp_row (
        .a_i     (a_q),
        .b_bit_i (b_bit),
        .row_i   (row_q),
        .v_i     (v_q),
        .pp_o    (pp_row)
    );

    always_comb begin
        acc_d = acc_q + ({{WIDTH{1'b0}}, pp_row} << row_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            v_q         <= '0;
            row_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.in_a;
                        b_q   <= bus.in_b;
                        v_q   <= v_acc;
                        row_q <= h_acc;
                        acc_q <= '0;
                        // Every row broken away: the result is known immediately.
                        if (h_acc >= HBITS'(WIDTH)) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_prod_q  <= '0;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    row_q <= row_q + HBITS'(1);
                    if (row_q == HBITS'(WIDTH - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_prod_q  <= acc_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
